axi_w_order_arbiter: RTL and testbench
======================================

// Module: axi_w_order_arbiter
// PURPOSE
//  Per-initiator-port W-channel arbiter of the AXI4 node. Merges write-data bursts from N_TARG_PORT
//  target-side W decoders onto one initiator port, strictly in the order the AW arbiter granted them.
//  AW side pushes the one-hot winner per accepted AW; bursts drain in FIFO order, locked until wlast.
// PARAMETERS
//  N_TARG_PORT  8   number of target (slave-side) requesters
//  FIFO_DEPTH   8   max AW grants outstanding without completed W burst (power of 2, >=2)
//  AXI_DATA_W   64  wdata width; AXI_STRB_W = AXI_DATA_W/8 derived
//  AXI_USER_W   6   wuser width
//  CNT_W        $clog2(FIFO_DEPTH+1), derived localparam
// PORTS
//  clk             in   1                       clock, rising edge
//  rst_n           in   1                       async reset, active low
//  test_en_i       in   1                       test mode, passed to FIFO
//  push_ID_i       in   1                       AW handshake done at this init port; push ID_i
//  ID_i            in   N_TARG_PORT             one-hot winning target of that AW
//  grant_FIFO_ID_o out  1                       FIFO not full; AW arbiter may accept
//  outstanding_o   out  CNT_W                   entries in FIFO
//  wvalid_i        in   N_TARG_PORT             per-target W valid
//  wdata_i         in   N_TARG_PORT*AXI_DATA_W  packed, target k at [k*AXI_DATA_W +: AXI_DATA_W]
//  wstrb_i         in   N_TARG_PORT*AXI_STRB_W  packed likewise
//  wlast_i         in   N_TARG_PORT             per-target last
//  wuser_i         in   N_TARG_PORT*AXI_USER_W  packed likewise
//  wready_o        out  N_TARG_PORT             per-target ready
//  wvalid_o/wdata_o/wstrb_o/wlast_o/wuser_o out 1/AXI_DATA_W/AXI_STRB_W/1/AXI_USER_W  merged W
//  wready_i        in   1                       initiator-port ready
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, outstanding_o=0, grant_FIFO_ID_o=1, wvalid_o=0, wready_o=0,
//    FSM=IDLE; mux data outputs 0. Reset mid-burst discards all queued IDs; no partial state kept.
//  - FIFO: registered, not fall-through. Push when push_ID_i & grant_FIFO_ID_o; pushed entry visible at
//    head next cycle earliest. push_ID_i while full: ignored, assertion error. ID_i non-one-hot: error.
//  - FSM IDLE (empty) -> ACTIVE when head valid; ACTIVE -> IDLE on pop leaving FIFO empty, else stays
//    ACTIVE with next head. Zero-bubble back-to-back bursts from different targets.
//  - ACTIVE: head = one-hot sel. wvalid_o=|(wvalid_i&sel); wdata/wstrb/wlast/wuser_o = AND-OR mux by
//    sel; wready_o = sel & {N{wready_i}}. Non-selected targets see wready_o=0 regardless of wvalid_i.
//  - IDLE: wvalid_o=0, wready_o=0, data outputs 0. Combinational valid/ready path, zero latency.
//  - Pop = wvalid_o & wready_i & wlast_o. Burst stays locked to head until that beat.
//  - Simultaneous push+pop: count unchanged; when full, pop does NOT enable same-cycle push
//    (grant depends only on registered count); grant rises the cycle after pop.
//  - outstanding_o: +1 push, -1 pop, unchanged on both; never wraps (0..FIFO_DEPTH).
//  - Output data stable while wvalid_o=1 & wready_i=0 provided selected source obeys AXI stability.
// CONFIGURATION
//  - Macro AXI_W_ORDER_LEN_CHECK_EN defined: extra ports awlen_i in 8 (pushed with ID_i) and
//    w_len_err_o out 1. FIFO width N_TARG_PORT+8; 8-bit beat counter cleared on pop/reset, +1 per beat
//    accepted. w_len_err_o sticky high from cycle after: wlast beat with count!=awlen, or
//    non-last beat with count==awlen. Cleared only by reset. Routing unaffected by error.
//  - Not defined: ports absent, FIFO width N_TARG_PORT, no counter.
// TESTING
//  - Reset: rst_n=0 -> grant_FIFO_ID_o=1, outstanding_o=0, wvalid_o=0, wready_o=0.
//  - Order: push ID=8'h01 then 8'h04; target2 valid first -> wready_o[2]=0; target0 3-beat burst
//    passes, pop on beat3, target2 beats pass next cycle, outstanding_o 2->1->0.
//  - Full: 8 pushes, no W -> grant=0, outstanding=8; 9th push ignored; one pop -> grant=1 next cycle.
//  - Backpressure: wready_i=0 for 4 cycles mid-burst -> wdata_o stable, no pop, wready_o[k]=0.
//  - Push+pop same cycle at outstanding=1 -> outstanding stays 1, next head selected next cycle.
//  - LEN_CHECK_EN: awlen=3, wlast on beat 2 -> w_len_err_o=1 next cycle, stays 1 until reset.

Source files
------------

// File: rtl/axi_w_order_arbiter.sv
// W-channel arbiter: replays AW grant order from an ID FIFO and locks the W mux to the head target until wlast.
// Optional build macro AXI_W_ORDER_LEN_CHECK_EN adds awlen_i / w_len_err_o burst length checking.
module axi_w_order_arbiter #(
  parameter int  N_TARG_PORT = 8,
  parameter int  FIFO_DEPTH  = 8,
  parameter int  AXI_DATA_W  = 64,
  parameter int  AXI_USER_W  = 6,
  localparam int AXI_STRB_W  = AXI_DATA_W / 8,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              test_en_i,
  input  logic                              push_ID_i,
  input  logic [N_TARG_PORT-1:0]            ID_i,
  output logic                              grant_FIFO_ID_o,
  output logic [CNT_W-1:0]                  outstanding_o,
  input  logic [N_TARG_PORT-1:0]            wvalid_i,
  input  logic [N_TARG_PORT*AXI_DATA_W-1:0] wdata_i,
  input  logic [N_TARG_PORT*AXI_STRB_W-1:0] wstrb_i,
  input  logic [N_TARG_PORT-1:0]            wlast_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0] wuser_i,
  output logic [N_TARG_PORT-1:0]            wready_o,
  output logic                              wvalid_o,
  output logic [AXI_DATA_W-1:0]             wdata_o,
  output logic [AXI_STRB_W-1:0]             wstrb_o,
  output logic                              wlast_o,
  output logic [AXI_USER_W-1:0]             wuser_o,
`ifdef AXI_W_ORDER_LEN_CHECK_EN
  input  logic [7:0]                        awlen_i,
  output logic                              w_len_err_o,
`endif
  input  logic                              wready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef AXI_W_ORDER_LEN_CHECK_EN
  localparam int FIFO_W = N_TARG_PORT + 8;
`else
  localparam int FIFO_W = N_TARG_PORT;
`endif

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FIFO_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [FIFO_W-1:0]      w_push_data;
  logic [FIFO_W-1:0]      w_head;
  logic [N_TARG_PORT-1:0] w_sel;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_beat;
  logic                   w_unused_test_en;

  assign w_unused_test_en = test_en_i;

  // Grant looks only at the registered count, so a pop while full frees a slot one cycle later.
  assign grant_FIFO_ID_o = (r_cnt != CNT_W'(FIFO_DEPTH));
  assign outstanding_o   = r_cnt;
  assign w_push          = push_ID_i & grant_FIFO_ID_o;
  assign w_head          = r_mem[r_rd_ptr];
  assign w_sel           = (r_state == S_ACTIVE) ? w_head[N_TARG_PORT-1:0] : '0;
  assign w_beat          = wvalid_o & wready_i;
  assign w_pop           = w_beat & wlast_o;

`ifdef AXI_W_ORDER_LEN_CHECK_EN
  assign w_push_data = {awlen_i, ID_i};
`else
  assign w_push_data = ID_i;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ACTIVE exactly while the FIFO holds an entry, so a freshly pushed ID is served the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_push) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_pop && !w_push && (r_cnt == CNT_W'(1))) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    wlast_o = 1'b0;
    wuser_o = '0;
    for (int k = 0; k < N_TARG_PORT; k++) begin
      wdata_o = wdata_o | (wdata_i[k*AXI_DATA_W +: AXI_DATA_W] & {AXI_DATA_W{w_sel[k]}});
      wstrb_o = wstrb_o | (wstrb_i[k*AXI_STRB_W +: AXI_STRB_W] & {AXI_STRB_W{w_sel[k]}});
      wuser_o = wuser_o | (wuser_i[k*AXI_USER_W +: AXI_USER_W] & {AXI_USER_W{w_sel[k]}});
      wlast_o = wlast_o | (wlast_i[k] & w_sel[k]);
    end
  end

  assign wvalid_o = |(wvalid_i & w_sel);
  assign wready_o = w_sel & {N_TARG_PORT{wready_i}};

`ifdef AXI_W_ORDER_LEN_CHECK_EN
  logic [7:0] r_beat_cnt;
  logic       r_len_err;
  logic [7:0] w_head_len;

  assign w_head_len  = w_head[N_TARG_PORT +: 8];
  assign w_len_err_o = r_len_err;

  // A beat is wrong when wlast disagrees with "this beat index equals awlen".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_pop)       r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;
      if (w_beat && (wlast_o != (r_beat_cnt == w_head_len))) r_len_err <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_push_full: assert property (@(posedge clk) disable iff (!rst_n) push_ID_i |-> grant_FIFO_ID_o)
    else $error("push_ID_i asserted while ID FIFO is full");
  a_id_onehot: assert property (@(posedge clk) disable iff (!rst_n) push_ID_i |-> $onehot(ID_i))
    else $error("ID_i is not one-hot on push");
`endif

endmodule

// File: tb/tb_axi_w_order_arbiter.sv
// Bench for axi_w_order_arbiter: directed vector table, hand sequences and random traffic vs a queue model.
module tb_axi_w_order_arbiter;

  localparam int N  = 8;
  localparam int D  = 8;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int UW = 6;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            test_en_i;
  logic            push_ID_i;
  logic [N-1:0]    ID_i;
  logic            grant_FIFO_ID_o;
  logic [CW-1:0]   outstanding_o;
  logic [N-1:0]    wvalid_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*SW-1:0] wstrb_i;
  logic [N-1:0]    wlast_i;
  logic [N*UW-1:0] wuser_i;
  logic [N-1:0]    wready_o;
  logic            wvalid_o;
  logic [DW-1:0]   wdata_o;
  logic [SW-1:0]   wstrb_o;
  logic            wlast_o;
  logic [UW-1:0]   wuser_o;
  logic            wready_i;
`ifdef AXI_W_ORDER_LEN_CHECK_EN
  logic [7:0]      awlen_i;
  logic            w_len_err_o;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int q[$];

  always #5 clk = ~clk;

  axi_w_order_arbiter #(
    .N_TARG_PORT(N), .FIFO_DEPTH(D), .AXI_DATA_W(DW), .AXI_USER_W(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
    .push_ID_i(push_ID_i), .ID_i(ID_i), .grant_FIFO_ID_o(grant_FIFO_ID_o),
    .outstanding_o(outstanding_o),
    .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wuser_i(wuser_i), .wready_o(wready_o),
    .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wuser_o(wuser_o),
`ifdef AXI_W_ORDER_LEN_CHECK_EN
    .awlen_i(awlen_i), .w_len_err_o(w_len_err_o),
`endif
    .wready_i(wready_i)
  );

  typedef struct {
    logic       push;
    logic [7:0] id;
    logic [7:0] wv;
    logic [7:0] wl;
    logic       wr;
    logic       e_vo;
    logic       e_lo;
    logic       e_gr;
    logic [7:0] e_ro;
    int         e_cnt;
    int         e_src;
  } vec_t;

  function automatic vec_t mk(logic push, logic [7:0] id, logic [7:0] wv, logic [7:0] wl, logic wr,
                              logic e_vo, logic e_lo, logic e_gr, logic [7:0] e_ro, int e_cnt, int e_src);
    vec_t v;
    v.push = push; v.id = id; v.wv = wv; v.wl = wl; v.wr = wr;
    v.e_vo = e_vo; v.e_lo = e_lo; v.e_gr = e_gr; v.e_ro = e_ro; v.e_cnt = e_cnt; v.e_src = e_src;
    return v;
  endfunction

  function automatic logic [DW-1:0] data_of(int k);
    return 64'h0123_4567_89AB_CDEF ^ {8{8'(k * 17 + 1)}};
  endfunction
  function automatic logic [SW-1:0] strb_of(int k);
    return 8'(k * 29 + 3);
  endfunction
  function automatic logic [UW-1:0] user_of(int k);
    return 6'(k * 5 + 1);
  endfunction

  function automatic int idx_of(logic [N-1:0] id);
    for (int k = 0; k < N; k++) if (id[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fill_fixed();
    for (int k = 0; k < N; k++) begin
      wdata_i[k*DW +: DW] = data_of(k);
      wstrb_i[k*SW +: SW] = strb_of(k);
      wuser_i[k*UW +: UW] = user_of(k);
    end
  endtask

  task automatic clear_inputs();
    push_ID_i = 1'b0; ID_i = '0; wvalid_i = '0; wlast_i = '0; wready_i = 1'b0;
`ifdef AXI_W_ORDER_LEN_CHECK_EN
    awlen_i = '0;
`endif
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: the queue holds target indices in grant order; its front owns the W channel.
  task automatic model_check(input string tag);
    int s;
    logic [N-1:0] one;
    one = 1;
    s = (q.size() > 0) ? q[0] : -1;
    chk({tag, "_outstanding"}, outstanding_o, q.size());
    chk({tag, "_grant"}, grant_FIFO_ID_o, q.size() < D);
    chk({tag, "_wvalid"}, wvalid_o, (s >= 0) ? wvalid_i[s] : 1'b0);
    chk({tag, "_wlast"}, wlast_o, (s >= 0) ? wlast_i[s] : 1'b0);
    chk({tag, "_wready"}, wready_o, (s >= 0 && wready_i) ? (one << s) : '0);
    chk({tag, "_wdata"}, wdata_o, (s >= 0) ? wdata_i[s*DW +: DW] : '0);
    chk({tag, "_wstrb"}, wstrb_o, (s >= 0) ? wstrb_i[s*SW +: SW] : '0);
    chk({tag, "_wuser"}, wuser_o, (s >= 0) ? wuser_i[s*UW +: UW] : '0);
  endtask

  task automatic model_update();
    int  s;
    bit  pop;
    bit  push;
    s    = (q.size() > 0) ? q[0] : -1;
    pop  = (s >= 0) && wvalid_i[s] && wready_i && wlast_i[s];
    push = push_ID_i && (q.size() < D);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(idx_of(ID_i));
  endtask

  task automatic drive(input logic push, input logic [7:0] id, input logic [7:0] wv,
                       input logic [7:0] wl, input logic wr);
    push_ID_i = push; ID_i = id; wvalid_i = wv; wlast_i = wl; wready_i = wr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[20];
    logic [N-1:0] one;
    one = 1;

    tbl[0]  = mk(1, 8'h01, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 0, -1);
    tbl[1]  = mk(1, 8'h04, 8'h04, 8'h00, 1, 0, 0, 1, 8'h01, 1,  0);
    tbl[2]  = mk(0, 8'h00, 8'h05, 8'h00, 1, 1, 0, 1, 8'h01, 2,  0);
    tbl[3]  = mk(0, 8'h00, 8'h05, 8'h00, 1, 1, 0, 1, 8'h01, 2,  0);
    tbl[4]  = mk(0, 8'h00, 8'h05, 8'h01, 1, 1, 1, 1, 8'h01, 2,  0);
    tbl[5]  = mk(0, 8'h00, 8'h04, 8'h00, 1, 1, 0, 1, 8'h04, 1,  2);
    tbl[6]  = mk(0, 8'h00, 8'h04, 8'h04, 1, 1, 1, 1, 8'h04, 1,  2);
    tbl[7]  = mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 0, -1);
    tbl[8]  = mk(1, 8'h08, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 0, -1);
    tbl[9]  = mk(0, 8'h00, 8'h08, 8'h00, 1, 1, 0, 1, 8'h08, 1,  3);
    tbl[10] = mk(0, 8'h00, 8'h08, 8'h00, 0, 1, 0, 1, 8'h00, 1,  3);
    tbl[11] = mk(0, 8'h00, 8'h08, 8'h00, 0, 1, 0, 1, 8'h00, 1,  3);
    tbl[12] = mk(0, 8'h00, 8'h08, 8'h00, 0, 1, 0, 1, 8'h00, 1,  3);
    tbl[13] = mk(0, 8'h00, 8'h08, 8'h00, 0, 1, 0, 1, 8'h00, 1,  3);
    tbl[14] = mk(0, 8'h00, 8'h08, 8'h08, 1, 1, 1, 1, 8'h08, 1,  3);
    tbl[15] = mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 0, -1);
    tbl[16] = mk(1, 8'h10, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 0, -1);
    tbl[17] = mk(1, 8'h20, 8'h10, 8'h10, 1, 1, 1, 1, 8'h10, 1,  4);
    tbl[18] = mk(0, 8'h00, 8'h20, 8'h20, 1, 1, 1, 1, 8'h20, 1,  5);
    tbl[19] = mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 0, -1);

    // Reset state, with every target requesting so zero outputs are meaningful
    rst_n = 1'b0;
    test_en_i = 1'b0;
    clear_inputs();
    fill_fixed();
    wvalid_i = '1; wlast_i = '1; wready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant_FIFO_ID_o, 1'b1);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_wvalid", wvalid_o, 1'b0);
    chk("rst_wready", wready_o, 8'h00);
    chk("rst_wdata", wdata_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();

    // Directed table: ordering, backpressure, push+pop at one outstanding
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].push, tbl[i].id, tbl[i].wv, tbl[i].wl, tbl[i].wr);
      #1;
      chk($sformatf("tbl%0d_wvalid", i), wvalid_o, tbl[i].e_vo);
      chk($sformatf("tbl%0d_wlast", i), wlast_o, tbl[i].e_lo);
      chk($sformatf("tbl%0d_grant", i), grant_FIFO_ID_o, tbl[i].e_gr);
      chk($sformatf("tbl%0d_wready", i), wready_o, tbl[i].e_ro);
      chk($sformatf("tbl%0d_outstanding", i), outstanding_o, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_wdata", i), wdata_o, (tbl[i].e_src >= 0) ? data_of(tbl[i].e_src) : 64'd0);
      chk($sformatf("tbl%0d_wstrb", i), wstrb_o, (tbl[i].e_src >= 0) ? strb_of(tbl[i].e_src) : 8'd0);
      chk($sformatf("tbl%0d_wuser", i), wuser_o, (tbl[i].e_src >= 0) ? user_of(tbl[i].e_src) : 6'd0);
      model_update();
    end

    // Full FIFO: eight grants, grant drops, one pop reopens it a cycle later
    reset_dut();
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      drive(1'b1, one << k, 8'h00, 8'h00, 1'b1);
      #1;
      chk($sformatf("full_fill%0d_outstanding", k), outstanding_o, k);
      chk($sformatf("full_fill%0d_grant", k), grant_FIFO_ID_o, 1'b1);
      model_update();
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("full_outstanding", outstanding_o, 8);
    chk("full_grant", grant_FIFO_ID_o, 1'b0);
    chk("full_head_wready", wready_o, 8'h01);
    model_update();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h01, 8'h01, 1'b1);
    #1;
    chk("full_pop_wlast", wlast_o, 1'b1);
    chk("full_pop_grant_same_cycle", grant_FIFO_ID_o, 1'b0);
    model_update();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("full_after_pop_grant", grant_FIFO_ID_o, 1'b1);
    chk("full_after_pop_outstanding", outstanding_o, 7);
    chk("full_after_pop_wready", wready_o, 8'h02);
    model_update();
    for (int k = 1; k < D; k++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, one << k, one << k, 1'b1);
      #1;
      chk($sformatf("drain%0d_wready", k), wready_o, one << k);
      chk($sformatf("drain%0d_outstanding", k), outstanding_o, D - k);
      model_update();
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    #1;
    chk("drain_end_outstanding", outstanding_o, 0);
    chk("drain_end_wvalid", wvalid_o, 1'b0);

    // Reset in the middle of a burst throws away all queued IDs
    reset_dut();
    @(negedge clk);
    drive(1'b1, 8'h40, 8'h00, 8'h00, 1'b1);
    #1;
    model_update();
    @(negedge clk);
    drive(1'b1, 8'h02, 8'h40, 8'h00, 1'b1);
    #1;
    chk("midrst_beat_wvalid", wvalid_o, 1'b1);
    model_update();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h40, 8'h00, 1'b1);
    #1;
    chk("midrst_pre_outstanding", outstanding_o, 2);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_outstanding", outstanding_o, 0);
    chk("midrst_grant", grant_FIFO_ID_o, 1'b1);
    chk("midrst_wvalid", wvalid_o, 1'b0);
    chk("midrst_wready", wready_o, 8'h00);
    chk("midrst_wdata", wdata_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h42, 8'h42, 1'b1);
    #1;
    model_check("midrst_rel");
    model_update();
    @(negedge clk);
    #1;
    model_check("midrst_rel2");
    model_update();

    // Random traffic against the queue model
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      push_ID_i = (q.size() < D) && ($urandom_range(0, 99) < ((c < 1500) ? 60 : 15));
      ID_i      = one << $urandom_range(0, N - 1);
      wvalid_i  = N'($urandom());
      wlast_i   = N'($urandom());
      wready_i  = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N * DW / 32; j++) wdata_i[j*32 +: 32] = $urandom();
      wstrb_i   = {$urandom(), $urandom()};
      wuser_i   = {$urandom(), $urandom()};
      #1;
      model_check($sformatf("rnd%0d", c));
      model_update();
    end

`ifdef AXI_W_ORDER_LEN_CHECK_EN
    // Length check: a correct 2-beat burst, then awlen=3 with wlast on beat index 2
    reset_dut();
    fill_fixed();
    @(negedge clk);
    drive(1'b1, 8'h01, 8'h00, 8'h00, 1'b1);
    awlen_i = 8'd1;
    #1;
    model_update();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h01, 8'h00, 1'b1);
    #1;
    chk("len_ok_b0_err", w_len_err_o, 1'b0);
    model_update();
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h01, 8'h01, 1'b1);
    #1;
    model_update();
    @(negedge clk);
    drive(1'b1, 8'h02, 8'h00, 8'h00, 1'b1);
    awlen_i = 8'd3;
    #1;
    chk("len_ok_done_err", w_len_err_o, 1'b0);
    model_update();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h02, (b == 2) ? 8'h02 : 8'h00, 1'b1);
      #1;
      chk($sformatf("len_bad_b%0d_err", b), w_len_err_o, 1'b0);
      chk($sformatf("len_bad_b%0d_wready", b), wready_o, 8'h02);
      model_update();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      #1;
      chk($sformatf("len_sticky%0d_err", c), w_len_err_o, 1'b1);
      model_update();
    end
    reset_dut();
    #1;
    chk("len_after_rst_err", w_len_err_o, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
